// File: rtl/touch_pkg.sv
// Shared definitions for the touch sample conditioning path:
// controller states, panel limits and the packed coordinate layout.
package touch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } touch_state_e;

   localparam int X_MAX_C = 799;
   localparam int Y_MAX_C = 479;

   // touch_data = {x, y}
   localparam int X_MSB = 31;
   localparam int X_LSB = 16;
   localparam int Y_MSB = 15;
   localparam int Y_LSB = 0;

endpackage

// File: rtl/touch_axis_acc.sv
// One coordinate axis: block reference, accumulator and jitter compare.
// avg_o is the average of the accumulator as it will be after this cycle's sample.
module touch_axis_acc
   import touch_pkg::*;
#(
   parameter int AVG_LOG2 = 2,
   parameter int JITTER   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] sample_i,
   input  logic        accept_i,
   input  logic        restart_i,
   output logic        within_jitter_o,
   output logic [15:0] avg_o
);

   localparam int AW = 16 + AVG_LOG2;
   localparam logic [15:0] JIT_W = 16'(JITTER);

   logic [15:0]   ref_q, ref_d, delta;
   logic [AW-1:0] acc_q, acc_d;

   always_comb begin
      delta           = (sample_i >= ref_q) ? (sample_i - ref_q) : (ref_q - sample_i);
      within_jitter_o = (delta <= JIT_W);
      ref_d           = ref_q;
      acc_d           = acc_q;
      if (accept_i) begin
         if (restart_i) begin
            ref_d = sample_i;
            acc_d = AW'(sample_i);
         end else begin
            acc_d = acc_q + AW'(sample_i);
         end
      end
      avg_o = acc_d[AW-1:AVG_LOG2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q <= '0;
         acc_q <= '0;
      end else begin
         ref_q <= ref_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/touch_filter.sv
// Debounces and averages raw touch samples into a packed {x,y} word;
// the word is forced to zero whenever no finger is being tracked.
module touch_filter
   import touch_pkg::*;
#(
   parameter int AVG_LOG2    = 2,
   parameter int JITTER      = 8,
   parameter int TIMEOUT_CYC = 5_000_000,
   parameter int X_MAX       = X_MAX_C,
   parameter int Y_MAX       = Y_MAX_C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        raw_valid,
   input  logic        raw_pressed,
   input  logic [15:0] raw_x,
   input  logic [15:0] raw_y,
   output logic [31:0] touch_data,
   output logic        touch_valid,
   output logic        touch_active
);

   localparam int CW = AVG_LOG2 + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] N_W     = CW'(1 << AVG_LOG2);
   localparam logic [TW-1:0] TO_W    = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] EXP_W   = TW'(TIMEOUT_CYC - 1);
   localparam logic [15:0]   X_MAX_W = 16'(X_MAX);
   localparam logic [15:0]   Y_MAX_W = 16'(Y_MAX);

   touch_state_e   state_q, state_d;
   logic [CW-1:0]  count_q, count_d, count_nxt;
   logic [TW-1:0]  timer_q, timer_d;
   logic [31:0]    data_q, data_d;
   logic           valid_q, valid_d, active_q;

   logic           accepted, release_s, expire, restart, complete;
   logic [1:0][15:0] axis_sample, axis_avg;
   logic [1:0]       axis_within;

   // index 1 carries x, index 0 carries y, matching the packed output order
   assign axis_sample = {raw_x, raw_y};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_axis
         touch_axis_acc #(
            .AVG_LOG2 (AVG_LOG2),
            .JITTER   (JITTER)
         ) u_acc (
            .clk             (clk),
            .rst_n           (rst_n),
            .sample_i        (axis_sample[gi]),
            .accept_i        (accepted),
            .restart_i       (restart),
            .within_jitter_o (axis_within[gi]),
            .avg_o           (axis_avg[gi])
         );
      end
   endgenerate

   assign accepted  = raw_valid && raw_pressed && (raw_x <= X_MAX_W) && (raw_y <= Y_MAX_W);
   assign release_s = raw_valid && !raw_pressed;
   assign expire    = (state_q != IDLE) && !accepted && (timer_q == EXP_W);
   assign restart   = (count_q == '0) || !(&axis_within);
   assign count_nxt = restart ? CW'(1) : (count_q + CW'(1));
   assign complete  = accepted && (count_nxt == N_W);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = 1'b0;

      if (state_q == IDLE || accepted) begin
         timer_d = '0;
      end else if (timer_q != TO_W) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = timer_q;
      end

      if (accepted) begin
         count_d = count_nxt;
         if (state_q == IDLE) begin
            state_d = ACQUIRE;
         end
         if (complete) begin
            count_d                = '0;
            state_d                = TRACK;
            data_d[X_MSB:X_LSB]    = axis_avg[1];
            data_d[Y_MSB:Y_LSB]    = axis_avg[0];
            // Pulse only when the word changes or tracking starts, so a
            // repeated identical average is not re-announced.
            valid_d = (state_q != TRACK) || (data_d != data_q);
         end
      end else if ((state_q != IDLE) && (release_s || expire)) begin
         state_d = IDLE;
         count_d = '0;
         timer_d = '0;
         if (state_q == TRACK) begin
            data_d  = '0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         timer_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         active_q <= (state_d == TRACK);
      end
   end

   assign touch_data   = data_q;
   assign touch_valid  = valid_q;
   assign touch_active = active_q;

endmodule

// File: tb/tb_touch_filter.sv
// Randomized and directed check of touch_filter against a block/queue-based
// behavioural model of the debounce, averaging and release rules.
module tb_touch_filter;

   localparam int TO  = 100;
   localparam int N   = 4;
   localparam int JIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        raw_valid = 1'b0, raw_pressed = 1'b0;
   logic [15:0] raw_x = '0, raw_y = '0;
   logic [31:0] touch_data;
   logic        touch_valid, touch_active;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: an in-progress block, the published word and idle time
   int   bx[$], by[$];
   bit   m_touch;
   logic [31:0] m_data;
   bit   m_valid;
   int   m_idle;

   touch_filter #(
      .AVG_LOG2    (2),
      .JITTER      (JIT),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_valid    (raw_valid),
      .raw_pressed  (raw_pressed),
      .raw_x        (raw_x),
      .raw_y        (raw_y),
      .touch_data   (touch_data),
      .touch_valid  (touch_valid),
      .touch_active (touch_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   function automatic void model_reset();
      bx.delete(); by.delete();
      m_touch = 0; m_data = '0; m_valid = 0; m_idle = 0;
   endfunction

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic void model_step();
      bit acc, rel, engaged;
      int sx, sy;
      m_valid = 0;
      acc = raw_valid && raw_pressed && (raw_x <= 799) && (raw_y <= 479);
      rel = raw_valid && !raw_pressed;
      engaged = m_touch || (bx.size() != 0);
      if (acc) begin
         m_idle = 0;
         if (bx.size() == 0 || absd(raw_x, bx[0]) > JIT || absd(raw_y, by[0]) > JIT) begin
            bx.delete(); by.delete();
         end
         bx.push_back(int'(raw_x)); by.push_back(int'(raw_y));
         if (bx.size() == N) begin
            sx = 0; sy = 0;
            foreach (bx[i]) begin sx += bx[i]; sy += by[i]; end
            if (!m_touch || {16'(sx / N), 16'(sy / N)} != m_data) m_valid = 1;
            m_data  = {16'(sx / N), 16'(sy / N)};
            m_touch = 1;
            bx.delete(); by.delete();
         end
      end else if (engaged) begin
         if (rel || m_idle == TO - 1) begin
            if (m_touch) begin m_data = '0; m_valid = 1; end
            m_touch = 0; m_idle = 0;
            bx.delete(); by.delete();
         end else begin
            m_idle++;
         end
      end
   endfunction

   task automatic cyc(input logic v, input logic p, input logic [15:0] x, input logic [15:0] y);
      raw_valid = v; raw_pressed = p; raw_x = x; raw_y = y;
      @(posedge clk);
      model_step();
      #1;
      chk("data",   touch_data, m_data);
      chk("valid",  {31'b0, touch_valid},  {31'b0, m_valid});
      chk("active", {31'b0, touch_active}, {31'b0, m_touch});
      raw_valid = 1'b0; raw_pressed = 1'b0;
   endtask

   task automatic smp(input logic [15:0] x, input logic [15:0] y);
      cyc(1'b1, 1'b1, x, y);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic rel();
      cyc(1'b1, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      int cx, cy, r;
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_data",   touch_data, 32'h0);
      chk("rst_valid",  {31'b0, touch_valid}, 32'h0);
      chk("rst_active", {31'b0, touch_active}, 32'h0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;

      // four consistent samples publish their average
      smp(16'h293, 16'h50); smp(16'h295, 16'h52); smp(16'h291, 16'h4E); smp(16'h293, 16'h50);
      chk("tp1_data",   touch_data, 32'h0293_0050);
      chk("tp1_valid",  {31'b0, touch_valid}, 32'h1);
      chk("tp1_active", {31'b0, touch_active}, 32'h1);
      idle(1);
      chk("tp1_pulse1", {31'b0, touch_valid}, 32'h0);

      // release zeroes the word once, further releases stay silent
      rel();
      chk("rel_data",   touch_data, 32'h0);
      chk("rel_valid",  {31'b0, touch_valid}, 32'h1);
      chk("rel_active", {31'b0, touch_active}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         rel();
         chk("rel_quiet", {31'b0, touch_valid}, 32'h0);
      end

      // jitter restart
      smp(16'h293, 16'h50); smp(16'h2A0, 16'h50); smp(16'h2A0, 16'h50); smp(16'h2A0, 16'h50);
      chk("tp2_quiet", {31'b0, touch_valid}, 32'h0);
      smp(16'h2A0, 16'h50);
      chk("tp2_data",  touch_data, 32'h02A0_0050);
      chk("tp2_valid", {31'b0, touch_valid}, 32'h1);

      // timeout exactly TO cycles after the last accepted sample
      idle(TO - 1);
      chk("to_pre_active", {31'b0, touch_active}, 32'h1);
      idle(1);
      chk("to_data",   touch_data, 32'h0);
      chk("to_valid",  {31'b0, touch_valid}, 32'h1);
      chk("to_active", {31'b0, touch_active}, 32'h0);

      // accepted sample in the expiry cycle keeps tracking
      for (int i = 0; i < 4; i++) smp(16'h100, 16'h80);
      chk("win_data", touch_data, 32'h0100_0080);
      idle(TO - 1);
      smp(16'h100, 16'h80);
      chk("win_active", {31'b0, touch_active}, 32'h1);
      chk("win_valid",  {31'b0, touch_valid}, 32'h0);
      idle(3);
      rel();

      // out-of-range pressed sample ignored inside a block
      smp(16'h120, 16'h90); smp(16'h120, 16'h90); smp(16'h400, 16'h90);
      smp(16'h120, 16'h90);
      chk("oor_quiet", {31'b0, touch_valid}, 32'h0);
      smp(16'h120, 16'h90);
      chk("oor_data", touch_data, 32'h0120_0090);

      // reset during ACQUIRE drops the partial block
      rel();
      smp(16'h200, 16'h100); smp(16'h200, 16'h100);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mrst_data",   touch_data, 32'h0);
      chk("mrst_active", {31'b0, touch_active}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      smp(16'h200, 16'h100); smp(16'h200, 16'h100); smp(16'h200, 16'h100);
      chk("mrst_quiet", {31'b0, touch_valid}, 32'h0);
      smp(16'h200, 16'h100);
      chk("mrst_data2", touch_data, 32'h0200_0100);

      // randomized traffic
      cx = 400; cy = 240;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) begin
            smp(16'(cx + int'($urandom_range(0, 20)) - 10), 16'(cy + int'($urandom_range(0, 20)) - 10));
         end else if (r < 65) begin
            cx = int'($urandom_range(10, 789)); cy = int'($urandom_range(10, 469));
            smp(16'(cx), 16'(cy));
         end else if (r < 68) begin
            if (r == 65) smp(16'(800 + $urandom_range(0, 1000)), 16'(cy));
            else         smp(16'(cx), 16'(480 + $urandom_range(0, 1000)));
         end else if (r < 71) begin
            rel();
         end else begin
            idle(1);
            if ($urandom_range(0, 149) == 0) idle(TO + 5);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/touch_filter.md
# touch_filter

Conditions raw touch-panel samples before they reach the touch-to-threshold decoder. It debounces presses and rejects jittery samples, then averages each block of 2^AVG_LOG2 consistent samples. The result is published as a packed 32-bit coordinate word, `touch_data = {x[15:0], y[15:0]}`. When no finger is present the output is forced to zero, a point outside every decoder hot-zone, so the downstream stage sees only stable, deliberate touches.

## Interface
- AVG_LOG2, 2: log2 of samples averaged per published point (block size N = 4).
- JITTER, 8: max allowed |delta| per axis between a sample and the first sample of its block.
- TIMEOUT_CYC, 5_000_000: cycles without an accepted sample before a touch is declared released (100 ms at 50 MHz).
- X_MAX, 799: largest legal x; samples with larger x are discarded.
- Y_MAX, 479: largest legal y; samples with larger y are discarded.
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- raw_valid  in  1  one-cycle strobe, raw sample present
- raw_pressed  in  1  sample reports finger down (qualified by raw_valid)
- raw_x  in  16  raw x coordinate
- raw_y  in  16  raw y coordinate
- touch_data  out  32  {x,y} averaged point; 0 when not touching
- touch_valid  out  1  one-cycle pulse whenever touch_data changes
- touch_active  out  1  high while in TRACK

## Operation
- Reset values: touch_data=0, touch_valid=0, touch_active=0, state=IDLE, accumulators, count and timer all 0.
- Accepted sample: raw_valid=1 with raw_pressed=1, raw_x<=X_MAX and raw_y<=Y_MAX.
  - Out-of-range pressed samples are ignored entirely; they do not restart the timer.
- Release sample: raw_valid=1 with raw_pressed=0.
- States:
  - IDLE: on an accepted sample, load ref=sample, acc=sample, count=1 → ACQUIRE. Release samples are ignored.
  - ACQUIRE: on an accepted sample:
    - If |x-ref_x|>JITTER or |y-ref_y|>JITTER: restart the block with ref=acc=sample, count=1.
    - Otherwise acc+=sample, count+=1.
    - When count reaches N: touch_data={acc_x>>AVG_LOG2, acc_y>>AVG_LOG2}, touch_valid=1 → TRACK, next block empty.
    - Release sample or timeout → IDLE, no output change.
  - TRACK: same block/jitter rules, with the first sample of each block becoming ref. Each completed block publishes a new point and pulses touch_valid.
    - Release sample or timeout: touch_data=0, touch_valid=1, discard partial block → IDLE.
- Arithmetic:
  - Accumulators are 16+AVG_LOG2 bits, unsigned, and never overflow.
  - Average is truncating (shift right).
  - Delta is an unsigned absolute difference; equality with JITTER passes.
- Timer: cleared by every accepted sample; counts in ACQUIRE/TRACK; saturates at TIMEOUT_CYC. Expiry is the cycle where timer==TIMEOUT_CYC-1 with no accepted sample.
- Simultaneous events:
  - An accepted sample in the expiry cycle wins: the timer clears and no release occurs.
  - A release sample always wins over a block completion, since they cannot coincide (one sample per strobe).
- Reset mid-operation: immediate return to reset values; any partial block is lost.

## Timing
- All outputs are registered.
- touch_data/touch_valid update on the clock edge after the raw_valid cycle carrying the Nth consistent sample, i.e. latency 1 cycle from the final sample.
- touch_valid is high for exactly one cycle per change and is never asserted twice for the same value.
- Back-to-back raw_valid on consecutive cycles is supported; throughput is one sample per cycle.
- touch_active rises with the first publication and falls with the zeroing publication, in the same cycle as touch_valid.

## Structure
- Shared touch package holds:
  - state enum (IDLE, ACQUIRE, TRACK);
  - X_MAX/Y_MAX panel constants;
  - packing helper constants (X field [31:16], Y field [15:0]).
- One sub-module, `touch_axis_acc`, instantiated twice (x, y). It holds ref, accumulator and the jitter compare, and outputs `within_jitter` and `avg`.
- Control FSM, count, timer and output registers stay in `touch_filter`.

## Test plan
- Four accepted samples (0x293,0x50),(0x295,0x52),(0x291,0x4E),(0x293,0x50) → one cycle after the 4th: touch_data=0x0293_0050, touch_valid pulse, touch_active=1.
- Samples (0x293,0x50),(0x2A0,0x50), then three of (0x2A0,0x50) → no publication until the 5th sample; the block restarts at 0x2A0; touch_data=0x02A0_0050.
- In TRACK, a release sample → next cycle touch_data=0, touch_valid pulse, touch_active=0; four further release samples produce nothing.
- TIMEOUT_CYC=100, TRACK, no samples → touch_data=0 with valid pulse exactly 100 cycles after the last sample.
  - Repeat with an accepted sample in the expiry cycle → stays in TRACK.
- Pressed sample x=0x400 interleaved in a block → ignored, block completes on 4 legal samples.
  - rst_n low during ACQUIRE → all outputs 0, and a fresh 4-sample block is required afterwards.
